// File: rtl/timer_pkg.sv
// Shared definitions for the MM:SS countdown timer: controller state encoding,
// default alarm length and the MCLK-derived auto-repeat timing defaults.
package timer_pkg;

    // Controller modes; also the encoding driven on the STATE_DBG port.
    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUNNING = 2'd1,
        ST_ALARM   = 2'd2
    } timer_state_t;

    // Board main clock frequency in Hz.
    localparam int MCLK_HZ = 25_175_000;

    // Number of 1 Hz ticks the alarm is shown before returning to STOPPED.
    localparam int ALARM_TICKS_DEF = 30;

    // Auto-repeat: 0.5 s hold before the first repeat, then one every 0.1 s.
    localparam int HOLD_CYCLES_DEF   = MCLK_HZ / 2;
    localparam int REPEAT_CYCLES_DEF = MCLK_HZ / 10;

endpackage

// File: rtl/btn_edge.sv
// Synchronous one-bit rising-edge detector for a debounced button level.
// The edge output is combinational from the current sample and the stored
// previous sample; the consumer registers it. The first sample after reset
// only loads history, so a button held through reset yields no edge.
module btn_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic level_i,
    output logic edge_o
);

    logic prev_q;
    logic valid_q;

    // History register and "history is meaningful" flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            prev_q  <= level_i;
            valid_q <= 1'b1;
        end
    end

    assign edge_o = valid_q & level_i & ~prev_q;

endmodule

// File: rtl/timer_ctrl.sv
// Sequencing controller for the MM:SS countdown timer. Turns button edges and
// the 1 Hz tick into single-cycle SEC_INC / MIN_INC / DEC / CLR strobes and
// owns the STOPPED / RUNNING / ALARM mode and the alarm blink.
// Optional build macro TIMER_CTRL_AUTOREPEAT_EN adds hold-to-repeat on the
// add-second / add-minute buttons while STOPPED.
//
// Strobe semantics: every strobe output is registered and is high for exactly
// the one cycle following the MCLK edge at which the causing sample (button
// edge or TICK) was taken; no handshake, the counters must accept every strobe.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int ALARM_TICKS   = ALARM_TICKS_DEF,
    parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
    input  logic       MCLK,
    input  logic       RST,
    input  logic       TICK,
    input  logic       BT_START,
    input  logic       BT_CLR,
    input  logic       BT_SEC,
    input  logic       BT_MIN,
    input  logic       ZERO,
    output logic       SEC_INC,
    output logic       MIN_INC,
    output logic       DEC,
    output logic       CLR,
    output logic       RUNNING,
    output logic       ENDED,
    output logic       BLANK,
    output logic [1:0] STATE_DBG
);

    localparam int ACW = $clog2(ALARM_TICKS + 1);

    // Zero-length alarms or repeat intervals would never terminate / fire.
    if (ALARM_TICKS < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_cfg
        $error("timer_ctrl: ALARM_TICKS, HOLD_CYCLES and REPEAT_CYCLES must be >= 1");
    end

    logic start_e, clr_e, sec_e, min_e;

    btn_edge u_edge_start (.clk_i(MCLK), .rst_i(RST), .level_i(BT_START), .edge_o(start_e));
    btn_edge u_edge_clr   (.clk_i(MCLK), .rst_i(RST), .level_i(BT_CLR),   .edge_o(clr_e));
    btn_edge u_edge_sec   (.clk_i(MCLK), .rst_i(RST), .level_i(BT_SEC),   .edge_o(sec_e));
    btn_edge u_edge_min   (.clk_i(MCLK), .rst_i(RST), .level_i(BT_MIN),   .edge_o(min_e));

    timer_state_t   state_q, state_d;
    logic           sec_inc_q, sec_inc_d;
    logic           min_inc_q, min_inc_d;
    logic           dec_q, dec_d;
    logic           clr_q, clr_d;
    logic           blank_q, blank_d;
    logic [ACW-1:0] acnt_q, acnt_d;
    logic [ACW-1:0] acnt_inc;

    assign acnt_inc = acnt_q + ACW'(1);

`ifdef TIMER_CTRL_AUTOREPEAT_EN
    // rep_cnt_q == 0 means no repeat armed; otherwise cycles since last strobe.
    logic [31:0] rep_cnt_q, rep_cnt_d;
    logic        rep_min_q, rep_min_d;      // 1: MIN is repeating, 0: SEC
    logic        rep_phase_q, rep_phase_d;  // 0: initial hold, 1: repeating
    logic        rep_hold;
    logic        rep_due;

    // Repeat continues only while the armed button is still the highest-priority held one.
    assign rep_hold = (rep_cnt_q != 32'd0) &&
                      (rep_min_q ? BT_MIN : (BT_SEC && !BT_MIN));
    assign rep_due  = rep_cnt_q == (rep_phase_q ? 32'(REPEAT_CYCLES) : 32'(HOLD_CYCLES));
`endif

    // Next-state and strobe decode; strobes default low, blank low outside ALARM.
    always_comb begin
        state_d   = state_q;
        sec_inc_d = 1'b0;
        min_inc_d = 1'b0;
        dec_d     = 1'b0;
        clr_d     = 1'b0;
        blank_d   = 1'b0;
        acnt_d    = '0;
`ifdef TIMER_CTRL_AUTOREPEAT_EN
        rep_cnt_d   = '0;
        rep_min_d   = rep_min_q;
        rep_phase_d = 1'b0;
`endif
        case (state_q)
            ST_STOPPED: begin
                if (clr_e) begin
                    clr_d = 1'b1;
                end else if (start_e) begin
                    if (!ZERO) state_d = ST_RUNNING;
                end else if (min_e) begin
                    min_inc_d = 1'b1;
`ifdef TIMER_CTRL_AUTOREPEAT_EN
                    rep_min_d = 1'b1;
                    rep_cnt_d = 32'd1;
`endif
                end else if (sec_e) begin
                    sec_inc_d = 1'b1;
`ifdef TIMER_CTRL_AUTOREPEAT_EN
                    rep_min_d = 1'b0;
                    rep_cnt_d = 32'd1;
`endif
                end else begin
`ifdef TIMER_CTRL_AUTOREPEAT_EN
                    if (rep_hold) begin
                        if (rep_due) begin
                            min_inc_d   = rep_min_q;
                            sec_inc_d   = !rep_min_q;
                            rep_cnt_d   = 32'd1;
                            rep_phase_d = 1'b1;
                        end else begin
                            rep_cnt_d   = rep_cnt_q + 32'd1;
                            rep_phase_d = rep_phase_q;
                        end
                    end
`endif
                end
            end
            ST_RUNNING: begin
                if (start_e) begin
                    state_d = ST_STOPPED;
                end else if (ZERO) begin
                    state_d = ST_ALARM;
                end else if (TICK) begin
                    dec_d = 1'b1;
                end
            end
            ST_ALARM: begin
                blank_d = blank_q;
                acnt_d  = acnt_q;
                if (clr_e) begin
                    clr_d   = 1'b1;
                    state_d = ST_STOPPED;
                    blank_d = 1'b0;
                    acnt_d  = '0;
                end else if (start_e) begin
                    state_d = ST_STOPPED;
                    blank_d = 1'b0;
                    acnt_d  = '0;
                end else if (TICK) begin
                    if (acnt_inc == ACW'(ALARM_TICKS)) begin
                        state_d = ST_STOPPED;
                        blank_d = 1'b0;
                        acnt_d  = '0;
                    end else begin
                        acnt_d  = acnt_inc;
                        blank_d = ~blank_q;
                    end
                end
            end
            default: state_d = ST_STOPPED;
        endcase
    end

    // State, strobe and counter registers with synchronous reset.
    always_ff @(posedge MCLK) begin
        if (RST) begin
            state_q   <= ST_STOPPED;
            sec_inc_q <= 1'b0;
            min_inc_q <= 1'b0;
            dec_q     <= 1'b0;
            clr_q     <= 1'b0;
            blank_q   <= 1'b0;
            acnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            sec_inc_q <= sec_inc_d;
            min_inc_q <= min_inc_d;
            dec_q     <= dec_d;
            clr_q     <= clr_d;
            blank_q   <= blank_d;
            acnt_q    <= acnt_d;
        end
    end

`ifdef TIMER_CTRL_AUTOREPEAT_EN
    // Auto-repeat timer registers.
    always_ff @(posedge MCLK) begin
        if (RST) begin
            rep_cnt_q   <= '0;
            rep_min_q   <= 1'b0;
            rep_phase_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_min_q   <= rep_min_d;
            rep_phase_q <= rep_phase_d;
        end
    end
`endif

    assign SEC_INC   = sec_inc_q;
    assign MIN_INC   = min_inc_q;
    assign DEC       = dec_q;
    assign CLR       = clr_q;
    assign BLANK     = blank_q;
    assign RUNNING   = (state_q == ST_RUNNING);
    assign ENDED     = (state_q == ST_ALARM);
    assign STATE_DBG = state_q;

endmodule
